// File: rtl/contador_ascendente_fpga.sv
// contador_ascendente_fpga: prescaled up-counter from 0 to a captured target,
// started/paused by an active-low run button, shown on two active-low hex digits.
module contador_ascendente_fpga #(
  parameter int unsigned N        = 6,
  parameter int unsigned TICK_DIV = 15_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic [N-1:0] a,
  output logic [N-1:0] z,
  output logic         done,
  output logic [6:0]   digit0,
  output logic [6:0]   digit1
);

  typedef enum logic [1:0] {IDLE, COUNT, PAUSE, DONE} state_t;

  localparam logic [31:0] PRE_LAST = 32'(TICK_DIV - 1);

  state_t       state;
  logic [31:0]  pre;
  logic [N-1:0] tgt;
  logic [N-1:0] z_inc;
  logic [3:0]   hi_nib;

  assign z_inc  = z + N'(1);
  // Upper digit is whatever lies above bit 3, zero-extended to a nibble.
  assign hi_nib = 4'(z >> 4);

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Control FSM: captures the target, runs the prescaler and advances the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pre   <= '0;
      tgt   <= '0;
      z     <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          z <= '0;
          if (!run) begin
            tgt <= a;
            if (a == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= COUNT;
              pre   <= '0;
            end
          end
        end
        COUNT: begin
          // A release on a terminal-count edge wins: pre stays at its last value
          // so the increment fires on the first edge after resume.
          if (run) begin
            state <= PAUSE;
          end else if (pre == PRE_LAST) begin
            pre <= '0;
            z   <= z_inc;
            if (z_inc == tgt) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            pre <= pre + 32'd1;
          end
        end
        PAUSE: begin
          if (!run) state <= COUNT;
        end
        DONE: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Display decode straight from the registered count.
  always_comb begin
    digit0 = seg7(z[3:0]);
    digit1 = seg7(hi_nib);
  end

endmodule

// File: tb/tb_contador_ascendente_fpga.sv
// Scoreboard bench for contador_ascendente_fpga with N=6, TICK_DIV=4.
module tb_contador_ascendente_fpga;

  localparam int TD = 4;

  logic       clk;
  logic       reset;
  logic       run;
  logic [5:0] a;
  logic [5:0] z;
  logic       done;
  logic [6:0] digit0;
  logic [6:0] digit1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0] z;
    logic       done;
  } exp_t;

  exp_t sb[$];

  contador_ascendente_fpga #(.N(6), .TICK_DIV(TD)) dut (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .a      (a),
    .z      (z),
    .done   (done),
    .digit0 (digit0),
    .digit1 (digit1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Push the expectation for the coming edge, then pop and compare once it has happened.
  task automatic tick(input string tag, input logic [5:0] ez, input logic ed);
    exp_t e;
    sb.push_back('{z: ez, done: ed});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".z"}, 32'(z), 32'(e.z));
    check({tag, ".done"}, 32'(done), 32'(e.done));
    check({tag, ".d0"}, 32'(digit0), 32'(seg_ref(e.z[3:0])));
    check({tag, ".d1"}, 32'(digit1), 32'(seg_ref({2'b00, e.z[5:4]})));
  endtask

  // Edge t=0 is the start edge. The run button is released for pause_len edges
  // from pause_at, and pressed again on the following edge; each of those
  // pause_len+1 edges delays the schedule by one cycle.
  task automatic run_case(input string name, input logic [5:0] tgt, input logic [5:0] a_late,
                          input int pause_at, input int pause_len, input int ncycles,
                          input int reset_at);
    int eff;
    int zq;
    logic [5:0] ez;
    reset = 1'b1; run = 1'b1; a = tgt;
    tick({name, ".rst"}, 6'd0, 1'b0);
    reset = 1'b0;
    tick({name, ".idle"}, 6'd0, 1'b0);
    for (int t = 0; t <= ncycles; t++) begin
      if (t == 1) a = a_late;
      if (t == reset_at) begin
        reset = 1'b1; run = 1'b0;
        tick({name, ".midrst"}, 6'd0, 1'b0);
        tick({name, ".midrst2"}, 6'd0, 1'b0);
        reset = 1'b0; run = 1'b1;
        tick({name, ".postrst"}, 6'd0, 1'b0);
        return;
      end
      run = (t >= pause_at && t < pause_at + pause_len);
      if (t < pause_at) eff = t;
      else if (t <= pause_at + pause_len) eff = pause_at - 1;
      else eff = t - pause_len - 1;
      zq = eff / TD;
      ez = (zq >= int'(tgt)) ? tgt : 6'(zq);
      tick(name, ez, zq >= int'(tgt));
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; a = '0;
    run_case("t1_cnt5",  6'd5,  6'd5,  100000, 0, 30,  28);
    run_case("t2_hex2c", 6'h2C, 6'h2C, 100000, 0, 180, 100000);
    check("t2_digit0_C", 32'(digit0), 32'(7'b1000110));
    check("t2_digit1_2", 32'(digit1), 32'(7'b0100100));
    run_case("t3_zero",  6'd0,  6'd0,  100000, 0, 5,   100000);
    check("t3_digit0_0", 32'(digit0), 32'(7'b1000000));
    run_case("t4_pause", 6'd10, 6'd10, 13, 7, 52, 100000);
    run_case("t4_tcrel", 6'd10, 6'd10, 16, 1, 44, 100000);
    run_case("t5_alate", 6'd10, 6'd2,  100000, 0, 46, 100000);
    run_case("t6_rstmid", 6'd10, 6'd10, 100000, 0, 40, 29);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
